rv_wb_sched: RTL and testbench

//  Writeback scheduler and scoreboard for the rv32 core's register file (2R/1W, x0 hardwired 0).
//  - Shares the single regfile write port between three sources: ALU (single-cycle), load unit (LD) and mul/div unit (MD).
//  - Tracks pending destination registers of multi-cycle ops and raises an issue stall on RAW/WAW hazards.
//  - Sits between the execute/memory stages and the regfile write port.

---
 rtl/rv_wb_sched.sv | 130 +++++++++++++
 tb/tb_rv_wb_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_sched.sv
// Writeback scheduler and register scoreboard for the rv32 regfile write port.
// Optional operand forwarding is enabled by defining RV_WB_FWD_EN.
module rv_wb_sched #(
  parameter int unsigned Nregs = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_wd,
  output logic        ld_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_wd,
  output logic        md_ready,
  input  logic        iss_ld,
  input  logic        iss_md,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  ars1,
  input  logic [4:0]  ars2,
  output logic        hz_stall,
  output logic        we,
  output logic [4:0]  awd,
  output logic [31:0] wd,
  output logic        fwd1,
  output logic        fwd2
);

  localparam int unsigned IdxW = (Nregs > 1) ? $clog2(Nregs) : 1;

  // rr_q: 0 = LD wins the next contested grant, 1 = MD wins.
  logic             rr_q, rr_d;
  logic [Nregs-1:0] pend_q, pend_d;
  logic             we_q;
  logic [4:0]       awd_q;
  logic [31:0]      wd_q;

  logic             gnt_alu, gnt_ld, gnt_md, gnt_any;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_wd;
  logic             wr1, wr2;

  function automatic logic in_range(input logic [4:0] r);
    return ({27'b0, r} < Nregs);
  endfunction

  function automatic logic [IdxW-1:0] idx(input logic [4:0] r);
    return r[IdxW-1:0];
  endfunction

  function automatic logic is_pend(input logic [4:0] r);
    return (r != 5'd0) && in_range(r) && pend_q[idx(r)];
  endfunction

  // Grants are suppressed during reset so an in-flight request is re-arbitrated afterwards.
  always_comb begin
    gnt_alu = ~reset & alu_we;
    gnt_ld  = ~reset & ~alu_we & ld_valid & (~md_valid | ~rr_q);
    gnt_md  = ~reset & ~alu_we & md_valid & (~ld_valid | rr_q);
    gnt_any = gnt_alu | gnt_ld | gnt_md;
    rr_d    = rr_q;
    if (~alu_we && ld_valid && md_valid) begin
      rr_d = ~rr_q;
    end
    sel_rd = alu_rd;
    sel_wd = alu_wd;
    if (gnt_ld) begin
      sel_rd = ld_rd;
      sel_wd = ld_wd;
    end else if (gnt_md) begin
      sel_rd = md_rd;
      sel_wd = md_wd;
    end
  end

  assign ld_ready = gnt_ld;
  assign md_ready = gnt_md;

  // Clear on writeback first so a same-cycle issue to the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (we_q && in_range(awd_q)) begin
      pend_d[idx(awd_q)] = 1'b0;
    end
    if ((iss_ld || iss_md) && (iss_rd != 5'd0) && in_range(iss_rd)) begin
      pend_d[idx(iss_rd)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= 1'b0;
      pend_q <= '0;
      we_q   <= 1'b0;
      awd_q  <= 5'd0;
      wd_q   <= 32'd0;
    end else begin
      rr_q   <= rr_d;
      pend_q <= pend_d;
      we_q   <= gnt_any;
      if (gnt_any) begin
        awd_q <= sel_rd;
        wd_q  <= sel_wd;
      end
    end
  end

  assign we  = we_q;
  assign awd = awd_q;
  assign wd  = wd_q;

  // The regfile read of a register being written this cycle is still stale.
  always_comb begin
    wr1 = we_q & (awd_q != 5'd0) & (awd_q == ars1);
    wr2 = we_q & (awd_q != 5'd0) & (awd_q == ars2);
`ifdef RV_WB_FWD_EN
    fwd1     = wr1;
    fwd2     = wr2;
    hz_stall = (is_pend(ars1) & ~wr1) | (is_pend(ars2) & ~wr2) | is_pend(iss_rd);
`else
    fwd1     = 1'b0;
    fwd2     = 1'b0;
    hz_stall = is_pend(ars1) | is_pend(ars2) | is_pend(iss_rd) | wr1 | wr2;
`endif
  end

endmodule

// File: tb/tb_rv_wb_sched.sv
// Directed bench for rv_wb_sched; expected writebacks are queued and checked as they appear.
module tb_rv_wb_sched;

`ifdef RV_WB_FWD_EN
  localparam logic Fwd = 1'b1;
`else
  localparam logic Fwd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_wd;
  logic        ld_ready;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_wd;
  logic        md_ready;
  logic        iss_ld;
  logic        iss_md;
  logic [4:0]  iss_rd;
  logic [4:0]  ars1;
  logic [4:0]  ars2;
  logic        hz_stall;
  logic        we;
  logic [4:0]  awd;
  logic [31:0] wd;
  logic        fwd1;
  logic        fwd2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  rv_wb_sched #(.Nregs(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_we   (alu_we),
    .alu_rd   (alu_rd),
    .alu_wd   (alu_wd),
    .ld_valid (ld_valid),
    .ld_rd    (ld_rd),
    .ld_wd    (ld_wd),
    .ld_ready (ld_ready),
    .md_valid (md_valid),
    .md_rd    (md_rd),
    .md_wd    (md_wd),
    .md_ready (md_ready),
    .iss_ld   (iss_ld),
    .iss_md   (iss_md),
    .iss_rd   (iss_rd),
    .ars1     (ars1),
    .ars2     (ars2),
    .hz_stall (hz_stall),
    .we       (we),
    .awd      (awd),
    .wd       (wd),
    .fwd1     (fwd1),
    .fwd2     (fwd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd = rd;
    e.wd = d;
    exp_q.push_back(e);
  endtask

  // Called once per cycle after inputs settle; consumes one queued write per we pulse.
  task automatic sample();
    wr_t e;
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL wb_unexpected: observed awd=%0d wd=0x%0h expected no write", awd, wd);
      end else begin
        e = exp_q.pop_front();
        check("wb_awd", {27'b0, awd}, {27'b0, e.rd});
        check("wb_wd", wd, e.wd);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    alu_we = 0; alu_rd = 0; alu_wd = 0;
    ld_valid = 0; ld_rd = 0; ld_wd = 0;
    md_valid = 0; md_rd = 0; md_wd = 0;
    iss_ld = 0; iss_md = 0; iss_rd = 0; ars1 = 0; ars2 = 0;

    // Reset with a pending LD request
    reset = 1; ld_valid = 1; ld_rd = 4; ld_wd = 32'hAA;
    tick(); sample();
    check("rst_we", {31'b0, we}, 0);
    check("rst_hz", {31'b0, hz_stall}, 0);
    check("rst_ldrdy", {31'b0, ld_ready}, 0);
    check("rst_awd", {27'b0, awd}, 0);
    check("rst_wd", wd, 0);
    tick(); reset = 0; sample();
    check("rel_ldrdy", {31'b0, ld_ready}, 1);
    check("rel_we", {31'b0, we}, 0);
    push(4, 32'hAA);

    // ALU priority over LD
    tick(); alu_we = 1; alu_rd = 3; alu_wd = 32'h11; ld_rd = 4; ld_wd = 32'h44;
    sample();
    check("pri_we_prev", {31'b0, we}, 1);
    check("pri_ldrdy0", {31'b0, ld_ready}, 0);
    push(3, 32'h11);
    tick(); alu_we = 0; sample();
    check("pri_ldrdy1", {31'b0, ld_ready}, 1);
    push(4, 32'h44);
    tick(); ld_valid = 0; sample();
    check("pri_we_ld", {31'b0, we}, 1);

    // Round robin LD, MD, LD
    tick(); ld_valid = 1; ld_rd = 5; ld_wd = 32'h55; md_valid = 1; md_rd = 6; md_wd = 32'h66;
    sample();
    check("rr1_ld", {31'b0, ld_ready}, 1);
    check("rr1_md", {31'b0, md_ready}, 0);
    push(5, 32'h55);
    tick(); sample();
    check("rr2_ld", {31'b0, ld_ready}, 0);
    check("rr2_md", {31'b0, md_ready}, 1);
    push(6, 32'h66);
    tick(); sample();
    check("rr3_ld", {31'b0, ld_ready}, 1);
    check("rr3_md", {31'b0, md_ready}, 0);
    push(5, 32'h55);
    tick(); ld_valid = 0; md_valid = 0; sample();

    // Scoreboard RAW on a load
    tick(); iss_ld = 1; iss_rd = 7; sample();
    check("sb_iss_hz", {31'b0, hz_stall}, 0);
    tick(); iss_ld = 0; iss_rd = 0; ars1 = 7; sample();
    check("sb_hz1", {31'b0, hz_stall}, 1);
    tick(); sample();
    check("sb_hz2", {31'b0, hz_stall}, 1);
    tick(); ld_valid = 1; ld_rd = 7; ld_wd = 32'h77; sample();
    check("sb_ldrdy", {31'b0, ld_ready}, 1);
    check("sb_hz3", {31'b0, hz_stall}, 1);
    push(7, 32'h77);
    tick(); ld_valid = 0; sample();
    check("sb_we", {31'b0, we}, 1);
    check("sb_hz_wr", {31'b0, hz_stall}, {31'b0, ~Fwd});
    check("sb_fwd1", {31'b0, fwd1}, {31'b0, Fwd});
    tick(); sample();
    check("sb_hz_done", {31'b0, hz_stall}, 0);
    check("sb_fwd1_off", {31'b0, fwd1}, 0);

    // Same-cycle set and clear of x9
    tick(); ars1 = 0; alu_we = 1; alu_rd = 9; alu_wd = 32'h99; sample();
    push(9, 32'h99);
    tick(); alu_we = 0; iss_md = 1; iss_rd = 9; sample();
    check("sc_we", {31'b0, we}, 1);
    check("sc_hz", {31'b0, hz_stall}, 0);
    tick(); iss_md = 0; iss_rd = 0; ars2 = 9; sample();
    check("sc_pend9", {31'b0, hz_stall}, 1);
    tick(); md_valid = 1; md_rd = 9; md_wd = 32'h9A; sample();
    check("sc_mdrdy", {31'b0, md_ready}, 1);
    push(9, 32'h9A);
    tick(); md_valid = 0; sample();
    check("sc_hz_wr", {31'b0, hz_stall}, {31'b0, ~Fwd});
    check("sc_fwd2", {31'b0, fwd2}, {31'b0, Fwd});
    tick(); sample();
    check("sc_hz_done", {31'b0, hz_stall}, 0);

    // x0 handling
    tick(); ars2 = 0; iss_ld = 1; iss_rd = 0; alu_we = 1; alu_rd = 0; alu_wd = 32'hDEAD;
    sample();
    check("x0_hz_iss", {31'b0, hz_stall}, 0);
    push(0, 32'hDEAD);
    tick(); iss_ld = 0; alu_we = 0; sample();
    check("x0_we", {31'b0, we}, 1);
    check("x0_hz", {31'b0, hz_stall}, 0);

    // Registers beyond Nregs are never pending, nor alias onto low indices
    tick(); iss_ld = 1; iss_rd = 20; sample();
    tick(); iss_ld = 0; iss_rd = 0; ars1 = 20; sample();
    check("oor_hz20", {31'b0, hz_stall}, 0);
    ars1 = 4; sample();
    check("oor_hz4", {31'b0, hz_stall}, 0);

    // Reset mid-operation clears pending state and drops the grant
    tick(); ars1 = 0; iss_ld = 1; iss_rd = 11; sample();
    tick(); iss_ld = 0; iss_rd = 0; ars1 = 11; sample();
    check("mid_hz_pre", {31'b0, hz_stall}, 1);
    tick(); reset = 1; ld_valid = 1; ld_rd = 10; ld_wd = 32'h100; sample();
    check("mid_ldrdy_rst", {31'b0, ld_ready}, 0);
    tick(); sample();
    check("mid_we_drop", {31'b0, we}, 0);
    check("mid_hz_clr", {31'b0, hz_stall}, 0);
    tick(); reset = 0; sample();
    check("mid_ldrdy_rel", {31'b0, ld_ready}, 1);
    push(10, 32'h100);
    tick(); ld_valid = 0; ars1 = 0; sample();
    check("mid_we", {31'b0, we}, 1);

    tick(); sample();
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
